// File: rtl/snake_game_ctrl_if.sv
// Key-pulse inputs and render-state outputs of the snake game sequencer.
// Latency: none, wires only.
// Backpressure: none; every signal is a pulse or a level that is always valid.
interface snake_game_ctrl_if;
  logic       frame_tick;
  logic       key_start;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic [1:0] game_state;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic [9:0] food_x;
  logic [9:0] food_y;
  logic [7:0] score;
  logic       step_pulse;

  // Key/timing source side.
  modport master (
    output frame_tick, key_start, key_up, key_down, key_left, key_right,
    input  game_state, box_x, box_y, food_x, food_y, score, step_pulse
  );

  // Game sequencer side.
  modport slave (
    input  frame_tick, key_start, key_up, key_down, key_left, key_right,
    output game_state, box_x, box_y, food_x, food_y, score, step_pulse
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/OVER FSM, frame-paced head stepping, food placement.
// Latency: one cycle from the stepping frame_tick (or key_start) to registered outputs.
// Backpressure: none; key pulses and frame ticks are consumed in the cycle they arrive.
module snake_game_ctrl #(
  parameter int H_DISP      = 800,
  parameter int V_DISP      = 600,
  parameter int BLOCK_W     = 10,
  parameter int STEP_FRAMES = 8
) (
  input logic              vga_clk,
  input logic              sys_rst,
  snake_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [9:0]  BW        = 10'(BLOCK_W);
  localparam logic [9:0]  X_MAX     = 10'(H_DISP - BLOCK_W);
  localparam logic [9:0]  Y_MAX     = 10'(V_DISP - BLOCK_W);
  localparam logic [9:0]  X_START   = 10'(H_DISP / 2);
  localparam logic [9:0]  Y_START   = 10'(V_DISP / 2);
  localparam logic [9:0]  X_FOOD0   = 10'(H_DISP / 4);
  localparam logic [9:0]  Y_FOOD0   = 10'(V_DISP / 4);
  localparam logic [6:0]  X_CELLS   = 7'(H_DISP / BLOCK_W);
  localparam logic [5:0]  Y_CELLS   = 6'(V_DISP / BLOCK_W);
  localparam logic [7:0]  LAST_FRM  = 8'(STEP_FRAMES - 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic dir_t reverse_of(input dir_t d);
    case (d)
      DIR_UP:   reverse_of = DIR_DOWN;
      DIR_DOWN: reverse_of = DIR_UP;
      DIR_LEFT: reverse_of = DIR_RIGHT;
      default:  reverse_of = DIR_LEFT;
    endcase
  endfunction

  state_t      state_q, state_d;
  dir_t        dir_q, dir_d;
  dir_t        pend_q, pend_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [9:0]  box_y_q, box_y_d;
  logic [9:0]  food_x_q, food_x_d;
  logic [9:0]  food_y_q, food_y_d;
  logic [7:0]  score_q, score_d;
  logic        step_q, step_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [15:0] lfsr_q, lfsr_d;

  logic        key_vld;
  dir_t        key_dir;
  logic [9:0]  next_x, next_y;
  logic        off_field;
  logic        eat;
  logic [6:0]  cell_x;
  logic [5:0]  cell_y;
  logic [9:0]  cand_x, cand_y;

  // Pick one direction key per cycle, highest priority up > down > left > right.
  always_comb begin
    key_vld = 1'b1;
    key_dir = DIR_RIGHT;
    if (bus.key_up)         key_dir = DIR_UP;
    else if (bus.key_down)  key_dir = DIR_DOWN;
    else if (bus.key_left)  key_dir = DIR_LEFT;
    else if (bus.key_right) key_dir = DIR_RIGHT;
    else                    key_vld = 1'b0;
  end

  // Candidate head position one cell along pend_dir, and whether that leaves the field.
  always_comb begin
    next_x    = box_x_q;
    next_y    = box_y_q;
    off_field = 1'b0;
    case (pend_q)
      DIR_UP: begin
        if (box_y_q == 10'd0) off_field = 1'b1;
        else                  next_y    = box_y_q - BW;
      end
      DIR_DOWN: begin
        if (box_y_q == Y_MAX) off_field = 1'b1;
        else                  next_y    = box_y_q + BW;
      end
      DIR_LEFT: begin
        if (box_x_q == 10'd0) off_field = 1'b1;
        else                  next_x    = box_x_q - BW;
      end
      default: begin
        if (box_x_q == X_MAX) off_field = 1'b1;
        else                  next_x    = box_x_q + BW;
      end
    endcase
    eat = (next_x == food_x_q) && (next_y == food_y_q);
  end

  // New food cell from the LFSR, nudged one cell right if it would land under the head.
  always_comb begin
    cell_x = lfsr_q[6:0];
    cell_y = lfsr_q[12:7];
    if (cell_x >= X_CELLS) cell_x = cell_x - X_CELLS;
    if (cell_y >= Y_CELLS) cell_y = cell_y - Y_CELLS;
    cand_x = {3'b000, cell_x} * BW;
    cand_y = {4'b0000, cell_y} * BW;
    if ((cand_x == next_x) && (cand_y == next_y)) begin
      cand_x = (cand_x >= X_MAX) ? 10'd0 : cand_x + BW;
    end
  end

  // Game FSM next state plus all datapath next-state values.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    pend_d      = pend_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    food_x_d    = food_x_q;
    food_y_d    = food_y_q;
    score_d     = score_q;
    step_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    case (state_q)
      ST_IDLE: begin
        if (bus.key_start) begin
          state_d     = ST_PLAY;
          box_x_d     = X_START;
          box_y_d     = Y_START;
          dir_d       = DIR_RIGHT;
          pend_d      = DIR_RIGHT;
          score_d     = 8'd0;
          frame_cnt_d = 8'd0;
        end
      end
      ST_PLAY: begin
        // A reversing key is dropped rather than queued.
        if (key_vld && (key_dir != reverse_of(dir_q))) pend_d = key_dir;
        if (bus.frame_tick) begin
          if (frame_cnt_q == LAST_FRM) begin
            frame_cnt_d = 8'd0;
            dir_d       = pend_q;
            if (off_field) begin
              state_d = ST_OVER;
            end else begin
              box_x_d = next_x;
              box_y_d = next_y;
              step_d  = 1'b1;
              if (eat) begin
                score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                food_x_d = cand_x;
                food_y_d = cand_y;
              end
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (bus.key_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset overrides any step evaluated in the same cycle.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      pend_q      <= DIR_RIGHT;
      box_x_q     <= X_START;
      box_y_q     <= Y_START;
      food_x_q    <= X_FOOD0;
      food_y_q    <= Y_FOOD0;
      score_q     <= 8'd0;
      step_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      food_x_q    <= food_x_d;
      food_y_q    <= food_y_d;
      score_q     <= score_d;
      step_q      <= step_d;
      frame_cnt_q <= frame_cnt_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign bus.game_state = state_q;
  assign bus.box_x      = box_x_q;
  assign bus.box_y      = box_y_q;
  assign bus.food_x     = food_x_q;
  assign bus.food_y     = food_y_q;
  assign bus.score      = score_q;
  assign bus.step_pulse = step_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with a step scoreboard.
// Latency: expects step results on the cycle after the stepping frame tick.
// Backpressure: none; all stimulus is pulses driven on the falling edge.
module tb_snake_game_ctrl;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] score;
  } step_exp_t;

  logic clk;
  logic rst;
  snake_game_ctrl_if bus ();

  snake_game_ctrl #(
    .H_DISP(800), .V_DISP(600), .BLOCK_W(10), .STEP_FRAMES(8)
  ) dut (
    .vga_clk(clk),
    .sys_rst(rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  step_exp_t sb_q[$];
  logic [15:0] m_lfsr;
  logic [15:0] lfsr_cap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: seeded in reset, shifts every clock.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every step_pulse must match the oldest expected step.
  always @(negedge clk) begin
    if (bus.step_pulse === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_step", 32'd1, 32'd0);
      end else begin
        step_exp_t e;
        e = sb_q.pop_front();
        chk("step_box_x", 32'(bus.box_x), 32'(e.x));
        chk("step_box_y", 32'(bus.box_y), 32'(e.y));
        chk("step_score", 32'(bus.score), 32'(e.score));
      end
    end
  end

  task automatic key_pulse(input logic s, input logic u, input logic d, input logic l, input logic r);
    bus.key_start = s; bus.key_up = u; bus.key_down = d; bus.key_left = l; bus.key_right = r;
    @(negedge clk);
    bus.key_start = 1'b0; bus.key_up = 1'b0; bus.key_down = 1'b0;
    bus.key_left = 1'b0; bus.key_right = 1'b0;
  endtask

  // Eight frame ticks; optionally queue the expected committed step.
  task automatic do_step(input logic expect_step, input int ex, input int ey, input int escore);
    step_exp_t e;
    if (expect_step) begin
      e.x = 10'(ex); e.y = 10'(ey); e.score = 8'(escore);
      sb_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      bus.frame_tick = 1'b1;
      if (i == 7) lfsr_cap = m_lfsr;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      @(negedge clk);
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  int x, y;
  int fx, fy;

  initial begin
    rst = 1'b1;
    bus.frame_tick = 1'b0; bus.key_start = 1'b0; bus.key_up = 1'b0;
    bus.key_down = 1'b0; bus.key_left = 1'b0; bus.key_right = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state",  32'(bus.game_state), 32'd0);
    chk("rst_box_x",  32'(bus.box_x), 32'd400);
    chk("rst_box_y",  32'(bus.box_y), 32'd300);
    chk("rst_food_x", 32'(bus.food_x), 32'd200);
    chk("rst_food_y", 32'(bus.food_y), 32'd150);
    chk("rst_score",  32'(bus.score), 32'd0);
    chk("rst_step",   32'(bus.step_pulse), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Direction keys and ticks in IDLE do nothing.
    key_pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_step(1'b0, 0, 0, 0);
    chk("idle_state", 32'(bus.game_state), 32'd0);

    // Game 1: first step right, reverse dropped, up beats right, then run into right wall.
    key_pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_state", 32'(bus.game_state), 32'd1);
    do_step(1'b1, 410, 300, 0);
    chk("play_state", 32'(bus.game_state), 32'd1);
    key_pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_step(1'b1, 420, 300, 0);
    key_pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_step(1'b1, 420, 290, 0);
    key_pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("start_in_play", 32'(bus.game_state), 32'd1);
    x = 420;
    while (x < 790) begin
      x += 10;
      do_step(1'b1, x, 290, 0);
    end
    do_step(1'b0, 0, 0, 0);
    chk("wall_state", 32'(bus.game_state), 32'd2);
    chk("wall_box_x", 32'(bus.box_x), 32'd790);
    chk("wall_box_y", 32'(bus.box_y), 32'd290);

    // OVER is frozen against ticks and direction keys.
    key_pulse(1'b0, 0, 1'b1, 1'b1, 1'b0);
    do_step(1'b0, 0, 0, 0);
    chk("over_state",  32'(bus.game_state), 32'd2);
    chk("over_box_x",  32'(bus.box_x), 32'd790);
    chk("over_box_y",  32'(bus.box_y), 32'd290);

    key_pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ack_state", 32'(bus.game_state), 32'd0);
    key_pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_state", 32'(bus.game_state), 32'd1);
    chk("restart_box_x", 32'(bus.box_x), 32'd400);
    chk("restart_box_y", 32'(bus.box_y), 32'd300);
    chk("restart_score", 32'(bus.score), 32'd0);

    // Game 2: walk up to row 150, then left to the food at (200,150).
    key_pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    y = 300;
    while (y > 150) begin
      y -= 10;
      do_step(1'b1, 400, y, 0);
    end
    key_pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    x = 400;
    while (x > 210) begin
      x -= 10;
      do_step(1'b1, x, 150, 0);
    end
    do_step(1'b1, 200, 150, 1);
    fx = int'(lfsr_cap[6:0]);
    fy = int'(lfsr_cap[12:7]);
    if (fx >= 80) fx -= 80;
    if (fy >= 60) fy -= 60;
    fx *= 10;
    fy *= 10;
    if (fx == 200 && fy == 150) fx = (fx + 10 > 790) ? 0 : fx + 10;
    chk("eat_food_x", 32'(bus.food_x), 32'(fx));
    chk("eat_food_y", 32'(bus.food_y), 32'(fy));
    chk("eat_food_off_head",
        32'((bus.food_x == bus.box_x) && (bus.food_y == bus.box_y)), 32'd0);
    chk("eat_score", 32'(bus.score), 32'd1);

    // Reset arriving on the stepping tick wins: no step, reset values.
    for (int i = 0; i < 7; i++) begin
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      @(negedge clk);
    end
    bus.frame_tick = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    chk("rststep_pulse", 32'(bus.step_pulse), 32'd0);
    chk("rststep_state", 32'(bus.game_state), 32'd0);
    chk("rststep_box_x", 32'(bus.box_x), 32'd400);
    chk("rststep_food_x", 32'(bus.food_x), 32'd200);
    chk("rststep_score", 32'(bus.score), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_final", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
